// File: rtl/memarb.sv
// Round-robin burst arbiter sharing one single-port memory controller among PORTS requesters.
// One grant at a time; address/length/direction are registered at grant, data and acks steered per word.
module memarb #(
    parameter int PORTS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [23*PORTS-1:0]   reqaddr,
    input  logic [32*PORTS-1:0]   reqwdata,
    input  logic [2*PORTS-1:0]    reqlen,
    input  logic [PORTS-1:0]      reqwr,
    input  logic [PORTS-1:0]      reqreq,
    output logic [PORTS-1:0]      reqack,
    output logic [31:0]           reqrdata,
    output logic [22:0]           memaddr,
    output logic [31:0]           memwdata,
    output logic [1:0]            memlen,
    output logic                  memwr,
    output logic                  memreq,
    input  logic                  memack,
    input  logic [31:0]           memrdata
);

    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] last_q, last_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          memreq_q, memreq_d;
    logic [22:0]   memaddr_q, memaddr_d;
    logic [1:0]    memlen_q, memlen_d;
    logic          memwr_q, memwr_d;

    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          any_req;

    // First requesting port searching upward from last+1, wrapping at PORTS.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        pick    = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = GW'((int'(last_q) + k) % PORTS);
            if (!any_req && reqreq[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        memreq_d  = memreq_q;
        memaddr_d = memaddr_q;
        memlen_d  = memlen_q;
        memwr_d   = memwr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    g_d      = pick;
                    memreq_d = 1'b1;
                    state_d  = BUSY;
                    for (int i = 0; i < PORTS; i++) begin
                        if (pick == GW'(i)) begin
                            memaddr_d = reqaddr[23*i +: 23];
                            memlen_d  = reqlen[2*i +: 2];
                            memwr_d   = reqwr[i];
                            cnt_d     = reqlen[2*i +: 2];
                        end
                    end
                end
            end
            BUSY: begin
                if (memack) begin
                    if (cnt_q == 2'd0) begin
                        memreq_d = 1'b0;
                        last_d   = g_q;
                        state_d  = GAP;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q   <= IDLE;
            g_q       <= '0;
            last_q    <= GW'(PORTS - 1);
            cnt_q     <= 2'd0;
            memreq_q  <= 1'b0;
            memaddr_q <= 23'd0;
            memlen_q  <= 2'd0;
            memwr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            memreq_q  <= memreq_d;
            memaddr_q <= memaddr_d;
            memlen_q  <= memlen_d;
            memwr_q   <= memwr_d;
        end
    end

    // Acks and write data are steered combinationally so the controller sees zero added latency.
    always_comb begin
        reqack   = '0;
        memwdata = 32'd0;
        for (int i = 0; i < PORTS; i++) begin
            if (state_q == BUSY && g_q == GW'(i)) begin
                reqack[i] = memack;
                memwdata  = reqwdata[32*i +: 32];
            end
        end
    end

    assign reqrdata = memrdata;
    assign memreq   = memreq_q;
    assign memaddr  = memaddr_q;
    assign memlen   = memlen_q;
    assign memwr    = memwr_q;

endmodule

// File: doc/memarb.md
# memarb

Round-robin arbiter that shares the single-port DDR controller `mem` (instantiated with `PORTS=1`) between several requesters: display scan-out, capture writer, CPU/debug. It holds one burst grant at a time and registers the winner's address, length and direction onto the controller's request port. It also steers per-word write data and acknowledges, and releases the grant only after the burst's final word.

## Interface
Parameters:
- `PORTS`, 4, number of requesters (2..8)

Ports:
- `clk` in 1: system clock
- `rstn` in 1: reset, asynchronous, active-low
- `reqaddr` in 23*PORTS: per-requester word address; port i at bits [23*i+22:23*i]
- `reqwdata` in 32*PORTS: per-requester write data; port i at [32*i+31:32*i]
- `reqlen` in 2*PORTS: per-requester burst length minus one (0..3 → 1..4 words)
- `reqwr` in PORTS: per-requester direction (1 = write)
- `reqreq` in PORTS: per-requester request, held until the final `reqack`
- `reqack` out PORTS: per-word acknowledge to the granted requester only
- `reqrdata` out 32: read data broadcast to all requesters; valid when that requester's `reqack` is high on a read
- `memaddr` out 23: address to `mem`
- `memwdata` out 32: write data to `mem`
- `memlen` out 2: burst length to `mem`
- `memwr` out 1: direction to `mem`
- `memreq` out 1: request to `mem`
- `memack` in 1: per-word acknowledge from `mem`
- `memrdata` in 32: read data from `mem`

## Operation
- Controller protocol, shared by both sides:
  - `memreq` is held high with stable addr/len/wr until `memlen+1` `memack` pulses have been received.
  - On a write, `memwdata` carries the current word and advances after each `memack`.
  - On a read, `memrdata` is valid in each `memack` cycle.
- Reset values: `memreq`=0, `memaddr`=0, `memlen`=0, `memwr`=0, `reqack`=0, grant=none, round-robin pointer `last`=PORTS-1, word counter=0, state IDLE.
- State machine:
  - IDLE: if any `reqreq` bit is set, pick the first set bit searching from `last+1` upward, modulo PORTS. Register `g`, `memaddr`, `memlen`, `memwr` from port g; set `memreq`=1 and counter=`reqlen[g]`; go to BUSY. Otherwise stay in IDLE.
  - BUSY: each `memack` forwards one `reqack[g]`. On `memack` with counter=0: clear `memreq`, set `last`=g, go to GAP. On `memack` with counter>0: decrement the counter.
  - GAP: one idle cycle with `memreq` low, then IDLE. Guarantees the controller sees a request edge between bursts.
- Combinational outputs:
  - `reqack[i] = memack & BUSY & (g==i)`
  - `memwdata` = `reqwdata` of port g, or 0 outside BUSY
  - `reqrdata = memrdata` unconditionally
- Address, length and direction are captured at grant. Later changes on the requester inputs during the burst are ignored.
- Deassertion of `reqreq[g]` mid-burst is a protocol violation. The arbiter still completes the burst and delivers the remaining acks.
- `memack` outside BUSY is ignored. No `reqack` is generated for it and no state changes.
- Fairness: a port that has just been served has the lowest priority in the next arbitration. Any continuously requesting port is granted within PORTS-1 intervening bursts.
- Asynchronous reset during BUSY aborts immediately: `memreq` drops to 0 and the state machine returns to IDLE. The controller must be reset with it.

## Timing
- Request latency: a `reqreq` rising at edge n gives `memreq`=1 after edge n+1, with all `mem*` fields valid in the same cycle.
- Ack latency: `reqack` is combinational from `memack`, so zero cycles.
- Final-ack cycle:
  - The final `memack` is at edge m.
  - `memreq`=0 after edge m.
  - GAP occupies cycle m+1.
  - The next grant's `memreq`=1 after edge m+2.
  - The minimum inter-burst dead time is 2 cycles at `memreq` low.
- Write data: `memwdata` follows the granted port's `reqwdata` with zero added latency. The requester presents word k+1 in the cycle after its k-th `reqack`.
- Back-to-back acks on consecutive cycles are supported for the full burst.

## Test plan
- Single read: port 2 requests addr 23'h2DBEEF, len 3. Required: `memreq` one cycle later with `memaddr`=23'h2DBEEF, `memlen`=3, `memwr`=0. Four `memack` pulses give four `reqack[2]` pulses with `reqrdata`=`memrdata` on each. `memreq` is low after the 4th pulse.
- Round-robin: all 4 ports request continuously, len 0. Required: grant order 0,1,2,3,0,1 and exactly one `reqack` per burst, to the granted port.
- Write steering: port 1 writes len 1 with `reqwdata[1]`=32'hCAFEF00D, then 32'h12345678 after the first ack; port 0 drives 32'hFFFFFFFF. Required: `memwdata` shows only port 1's words.
- Gap/back-to-back: ports 0 and 3 request; the final ack of port 0 is at edge m. Required: `memreq` low during cycles m and m+1, then high with port 3's address after edge m+2.
- Stray ack and mid-burst drop:
  - `memack` pulsed in IDLE. Required: no `reqack`, state unchanged.
  - Port 0 drops `reqreq` after 1 of 4 acks. Required: 3 further `reqack[0]` pulses, then release.
- Reset mid-burst: assert `rstn`=0 asynchronously during the 2nd word. Required: `memreq`=0 and `reqack`=0 before the next edge. After release, the first grant goes to port 0.
